serial_addsub_unit: RTL

SERIAL_ADDSUB_UNIT -- requirements
Module: serial_addsub_unit

---
 rtl/addsub_pkg.sv | 23 ++
 rtl/addsub_slice.sv | 15 +
 rtl/serial_addsub_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared encodings for the serial add/subtract unit: operation codes, FSM
// states and a helper that sizes the slice counter.
package addsub_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_ADC = 2'b01,
      OP_SUB = 2'b10,
      OP_SBB = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_CPLT = 2'b10
   } state_e;

   // A single-slice configuration still needs a one-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit adder with carry in and carry out; the serial unit
// reuses one instance for every slice of the operands.
module addsub_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/serial_addsub_unit.sv
// Slice-serial ADD/ADC/SUB/SBB unit: processes SLICE bits per cycle, LSB first,
// and publishes Y/COUT/OVF/C_FLAG on the cycle DONE pulses. WIDTH must be a
// multiple of SLICE.
module serial_addsub_unit
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [1:0]       OP,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_LOAD,
   input  logic             C_IN,
   output logic [WIDTH-1:0] Y,
   output logic             COUT,
   output logic             OVF,
   output logic             C_FLAG,
   output logic             BUSY,
   output logic             DONE
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_e           state_q, state_d;
   logic             sub_q, sub_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             c_flag_q, c_flag_d;

   logic [31:0]      base;
   logic [SLICE-1:0] s_a, s_b, s_sum;
   logic             s_cout;
   logic             cin0;

   assign base = 32'(cnt_q) * 32'(SLICE);
   assign s_a  = a_q[base +: SLICE];
   assign s_b  = b_q[base +: SLICE];

   addsub_slice #(.W(SLICE)) u_slice (
      .a    (s_a),
      .b    (s_b),
      .cin  (carry_q),
      .sum  (s_sum),
      .cout (s_cout)
   );

   // Carry into the LSB slice; subtraction adds the inverted B operand.
   always_comb begin
      cin0 = 1'b0;
      unique case (op_e'(OP))
         OP_ADD: cin0 = 1'b0;
         OP_ADC: cin0 = c_flag_q;
         OP_SUB: cin0 = 1'b1;
         OP_SBB: cin0 = ~c_flag_q;
         default: cin0 = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      sub_d    = sub_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      y_d      = y_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      c_flag_d = c_flag_q;

      unique case (state_q)
         ST_IDLE, ST_CPLT: begin
            if (START) begin
               state_d = ST_RUN;
               sub_d   = OP[1];
               a_d     = A;
               b_d     = OP[1] ? ~B : B;
               carry_d = cin0;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
               if (C_LOAD) c_flag_d = C_IN;
            end
         end
         ST_RUN: begin
            res_d[base +: SLICE] = s_sum;
            carry_d = s_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Results become architecturally visible only at completion.
               state_d  = ST_CPLT;
               cnt_d    = '0;
               y_d      = res_d;
               cout_d   = s_cout;
               ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
               c_flag_d = sub_q ? ~s_cout : s_cout;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         sub_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         y_q      <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         c_flag_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sub_q    <= sub_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         y_q      <= y_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         c_flag_q <= c_flag_d;
      end
   end

   assign Y      = y_q;
   assign COUT   = cout_q;
   assign OVF    = ovf_q;
   assign C_FLAG = c_flag_q;
   assign BUSY   = (state_q == ST_RUN);
   assign DONE   = (state_q == ST_CPLT);

endmodule
